// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the fetch/dispatch entry carried between the front-end stages.
package pipeline_pkg;

  localparam int unsigned FD_W = 32;

  typedef struct packed {
    logic [FD_W-1:0] instr;
    logic [FD_W-1:0] pc;
  } fd_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch and dispatch. Outputs come only from
// registered state, so fetch and dispatch timing paths stay decoupled.
module fetch_buffer
  import pipeline_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = FD_W
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_instr,
  input  logic [WORD_W-1:0]        in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WORD_W-1:0]        out_instr,
  output logic [WORD_W-1:0]        out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fd_t              mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  fd_t              wr_entry;
  fd_t              head;

  always_comb begin
    in_ready  = (cnt_q != CNT_W'(DEPTH));
    out_valid = (cnt_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    count     = cnt_q;

    head      = mem_q[rd_ptr_q];
    out_instr = out_valid ? WORD_W'(head.instr) : '0;
    out_pc    = out_valid ? WORD_W'(head.pc) : '0;

    wr_entry.instr = FD_W'(in_instr);
    wr_entry.pc    = FD_W'(in_pc);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Flush and reset only rewind the bookkeeping; stale storage is unreachable once cnt is 0.
  always_ff @(posedge CLK) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= wr_entry;
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomised and directed stimulus for fetch_buffer, checked by a queue-based
// reference model and a negedge monitor.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic         CLK = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_instr, in_pc;
  logic         in_ready, out_valid;
  logic [W-1:0] out_instr, out_pc;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    logic [W-1:0] instr;
    logic [W-1:0] pc;
  } ent_t;

  ent_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pops   = 0;
  bit   started  = 1'b0;
  int   sz;

  fetch_buffer #(.DEPTH(DEPTH), .WORD_W(W)) dut (
    .CLK(CLK), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .count(count)
  );

  always #5 CLK = ~CLK;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: an ordered list of accepted entries, updated at each edge.
  always @(posedge CLK) begin
    if (rst || flush) begin
      exp_q.delete();
      if (rst) started <= 1'b1;
    end else begin
      sz = exp_q.size();
      if (sz != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && sz < DEPTH) exp_q.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  // Monitor: compare DUT outputs with the model mid-cycle, log each dispatch.
  always @(negedge CLK) begin
    if (started) begin
      check("count", 64'(count), 64'(exp_q.size()));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
      if (exp_q.size() != 0) begin
        check("head_instr", 64'(out_instr), 64'(exp_q[0].instr));
        check("head_pc", 64'(out_pc), 64'(exp_q[0].pc));
        if (out_ready && !rst && !flush) begin
          n_pops++;
          $display("pop %0d: pc=0x%08h instr=0x%08h count=%0d", n_pops, out_pc, out_instr, count);
        end
      end else begin
        check("idle_instr", 64'(out_instr), 64'd0);
        check("idle_pc", 64'(out_pc), 64'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] ins, input logic [W-1:0] pc,
                       input logic rdy, input logic fl, input logic r);
    @(posedge CLK);
    #1;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    rst       = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (3) @(posedge CLK);
    idle(2);

    // Single push, then dispatch it.
    drive(1'b1, 32'h0000_0013, 32'h100, 1'b0, 1'b0, 1'b0);
    idle(2);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Fill, reject a fifth push, then drain in order.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hdead_beef, 32'h10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Full with simultaneous push and pop: only the pop happens.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, 32'h200 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h1111_1111, 32'h300, 1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Prefill one, then stream 10 items with a push and pop every cycle.
    drive(1'b1, 32'h0000_0aaa, 32'h400, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, $urandom, 32'(i * 4), 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Flush at count=3 with a competing push and pop.
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 32'h500 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h2222_2222, 32'h600, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Reset at count=2 behaves the same.
    for (int i = 0; i < 2; i++) drive(1'b1, $urandom, 32'h700 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h3333_3333, 32'h800, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 199) == 0));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
